// File: rtl/lif_pkg.sv
// Shared definitions for the LIF neuron and its spike decoders.
// Default widths and the saturating arithmetic used by both sides.
package lif_pkg;

   localparam int RATE_W_DEF      = 8;
   localparam int ISI_W_DEF       = 8;
   localparam int WINDOW_LOG2_DEF = 8;

   function automatic logic [31:0] sat_inc(
      input logic [31:0] v,
      input logic [31:0] max
   );
      return (v >= max) ? max : v + 32'd1;
   endfunction

endpackage

// File: rtl/isi_timer.sv
// Inter-spike interval timer: counts enabled cycles between onsets
// and publishes the most recent interval, saturating at full scale.
module isi_timer
   import lif_pkg::*;
#(
   parameter int ISI_W = ISI_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             onset,
   output logic [ISI_W-1:0] isi
);

   localparam logic [31:0] ISI_MAX = 32'((64'd1 << ISI_W) - 64'd1);

   logic [ISI_W-1:0] gap;
   logic [ISI_W-1:0] gap_inc;
   logic             seen;

   assign gap_inc = ISI_W'(sat_inc(32'(gap), ISI_MAX));

   always_ff @(posedge clk) begin
      if (reset) begin
         gap  <= '0;
         seen <= 1'b0;
         isi  <= '0;
      end else if (en) begin
         if (onset) begin
            // gap+1 is the number of enabled cycles between onsets
            if (seen) isi <= gap_inc;
            gap  <= '0;
            seen <= 1'b1;
         end else begin
            gap <= gap_inc;
         end
      end
   end

endmodule

// File: rtl/spike_rate_decoder.sv
// Rate and ISI decoder for a one-bit spike train, with a
// valid/ready holding register and sticky overrun flag.
module spike_rate_decoder
   import lif_pkg::*;
#(
   parameter int WINDOW_LOG2 = WINDOW_LOG2_DEF,
   parameter int RATE_W      = RATE_W_DEF,
   parameter int ISI_W       = ISI_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              spike,
   input  logic              en,
   output logic [RATE_W-1:0] rate,
   output logic [ISI_W-1:0]  isi,
   output logic              valid,
   input  logic              ready,
   output logic              overrun
);

   localparam logic [31:0] RATE_MAX = 32'((64'd1 << RATE_W) - 64'd1);

   logic                   spike_q;
   logic                   onset;
   logic [WINDOW_LOG2-1:0] wcnt;
   logic                   window_end;
   logic [RATE_W-1:0]      acc;
   logic [RATE_W-1:0]      acc_next;

   // en gates the edge, so a held spike re-enabled never re-fires
   assign onset      = spike & ~spike_q & en;
   assign window_end = en & (wcnt == '1);
   assign acc_next   = onset ? RATE_W'(sat_inc(32'(acc), RATE_MAX)) : acc;

   always_ff @(posedge clk) begin
      if (reset) begin
         spike_q <= 1'b0;
         wcnt    <= '0;
         acc     <= '0;
         rate    <= '0;
         valid   <= 1'b0;
         overrun <= 1'b0;
      end else begin
         spike_q <= spike;
         if (en) wcnt <= wcnt + WINDOW_LOG2'(1);
         if (window_end) begin
            acc   <= '0;
            rate  <= acc_next;
            valid <= 1'b1;
            if (valid & ~ready) overrun <= 1'b1;
         end else begin
            acc <= acc_next;
            if (valid & ready) valid <= 1'b0;
         end
      end
   end

   isi_timer #(
      .ISI_W(ISI_W)
   ) u_isi (
      .clk  (clk),
      .reset(reset),
      .en   (en),
      .onset(onset),
      .isi  (isi)
   );

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Randomized and directed bench for spike_rate_decoder, checked every
// cycle against an enabled-cycle-index model of rate, isi and handshake.
module tb_spike_rate_decoder;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       spike = 1'b0;
   logic       en = 1'b1;
   logic       ready = 1'b1;
   logic [7:0] rate_a, isi_a, rate_b, isi_b;
   logic       valid_a, valid_b, ovr_a, ovr_b;

   int n_total = 0;
   int n_pass  = 0;

   always #5 clk = ~clk;

   spike_rate_decoder #(.WINDOW_LOG2(4), .RATE_W(8), .ISI_W(8)) dut_a (
      .clk(clk), .reset(reset), .spike(spike), .en(en),
      .rate(rate_a), .isi(isi_a), .valid(valid_a),
      .ready(ready), .overrun(ovr_a)
   );

   spike_rate_decoder #(.WINDOW_LOG2(10), .RATE_W(8), .ISI_W(8)) dut_b (
      .clk(clk), .reset(reset), .spike(spike), .en(en),
      .rate(rate_b), .isi(isi_b), .valid(valid_b),
      .ready(ready), .overrun(ovr_b)
   );

   task automatic chk(input string nm, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
   endtask

   function automatic int sat8(input int v);
      return (v > 255) ? 255 : v;
   endfunction

   // Model: n = index of enabled cycles since reset; a window closes at
   // every n with n % W == W-1; isi is the index difference of onsets.
   int wlen[2] = '{16, 1024};
   int m_n[2], m_cnt[2], m_last[2], m_rate[2], m_isi[2];
   bit m_seen[2], m_valid[2], m_ovr[2], m_spq[2];
   bit armed = 0;

   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (reset) begin
            m_n[k] = 0; m_cnt[k] = 0; m_last[k] = 0;
            m_rate[k] = 0; m_isi[k] = 0; m_seen[k] = 0;
            m_valid[k] = 0; m_ovr[k] = 0; m_spq[k] = 0;
            armed = 1;
         end else begin
            if (en) begin
               if (spike && !m_spq[k]) begin
                  m_cnt[k]++;
                  if (m_seen[k]) m_isi[k] = sat8(m_n[k] - m_last[k]);
                  m_last[k] = m_n[k];
                  m_seen[k] = 1;
               end
               if (m_n[k] % wlen[k] == wlen[k] - 1) begin
                  if (m_valid[k] && !ready) m_ovr[k] = 1;
                  m_rate[k] = sat8(m_cnt[k]);
                  m_cnt[k] = 0;
                  m_valid[k] = 1;
               end else if (m_valid[k] && ready) begin
                  m_valid[k] = 0;
               end
               m_n[k]++;
            end else if (m_valid[k] && ready) begin
               m_valid[k] = 0;
            end
            m_spq[k] = spike;
         end
      end
   end

   always @(negedge clk) begin
      if (armed) begin
         chk("rate_w4", rate_a, m_rate[0]);
         chk("isi_w4", isi_a, m_isi[0]);
         chk("valid_w4", valid_a, m_valid[0]);
         chk("overrun_w4", ovr_a, m_ovr[0]);
         chk("rate_w10", rate_b, m_rate[1]);
         chk("isi_w10", isi_b, m_isi[1]);
         chk("valid_w10", valid_b, m_valid[1]);
         chk("overrun_w10", ovr_b, m_ovr[1]);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic align_a();
      while (m_n[0] % 16 != 0) tick();
   endtask

   task automatic run_win(input logic [15:0] mask,
                          input logic r_first, input logic r_last);
      for (int p = 0; p < 16; p++) begin
         spike = mask[p];
         ready = (p == 0) ? r_first : ((p == 15) ? r_last : 1'b0);
         tick();
      end
      spike = 1'b0;
   endtask

   initial begin
      int t;
      reset = 1'b1;
      repeat (3) tick();
      chk("reset_rate", rate_a, 0);
      chk("reset_isi", isi_a, 0);
      chk("reset_valid", valid_a, 0);
      chk("reset_overrun", ovr_a, 0);

      // first valid is visible in cycle 17 after deassertion
      reset = 1'b0;
      for (t = 1; t <= 40; t++) begin
         tick();
         if (valid_a) break;
      end
      chk("first_valid_cycle", t + 1, 17);

      for (int i = 0; i < 64; i++) begin
         spike = (i % 4 == 0);
         tick();
      end
      spike = 1'b0;
      chk("periodic_rate", rate_a, 4);
      chk("periodic_isi", isi_a, 4);
      chk("periodic_valid", valid_a, 1);
      tick();
      chk("periodic_valid_pulse", valid_a, 0);

      align_a();
      for (int p = 0; p < 16; p++) begin
         spike = (p < 10);
         tick();
      end
      spike = 1'b0;
      chk("held_rate", rate_a, 1);

      for (t = 1; t <= 40; t++) begin
         en = !(t >= 6 && t <= 10);
         tick();
         if (valid_a) break;
      end
      en = 1'b1;
      chk("en_stretch_cycles", t, 21);

      for (t = 1; t <= 40; t++) begin
         en = (t > 10) || (t % 2 == 1);
         spike = (t <= 12);
         tick();
         if (valid_a) break;
      end
      en = 1'b1;
      spike = 1'b0;
      chk("en_toggle_rate", rate_a, 1);

      align_a();
      run_win(16'h8000, 1'b1, 1'b1);
      chk("last_cycle_rate", rate_a, 1);
      ready = 1'b1;
      for (int i = 0; i < 300; i++) begin
         tick();
         if (i == 15) chk("next_window_rate", rate_a, 0);
      end
      spike = 1'b1;
      tick();
      spike = 1'b0;
      chk("isi_saturate", isi_a, 255);

      while (m_n[1] % 1024 != 0) tick();
      for (int i = 0; i < 1024; i++) begin
         spike = (i % 2 == 0);
         tick();
      end
      spike = 1'b0;
      chk("w10_rate_sat", rate_b, 255);
      chk("w10_valid", valid_b, 1);
      chk("w10_isi", isi_b, 2);

      align_a();
      run_win(16'h0444, 1'b1, 1'b0);
      chk("bp_rate_a", rate_a, 3);
      chk("bp_overrun_a", ovr_a, 0);
      run_win(16'h02AA, 1'b0, 1'b0);
      chk("bp_rate_b", rate_a, 5);
      chk("bp_valid_b", valid_a, 1);
      chk("bp_overrun_b", ovr_a, 1);
      run_win(16'h000A, 1'b0, 1'b1);
      chk("same_cycle_valid", valid_a, 1);
      chk("same_cycle_rate", rate_a, 2);
      ready = 1'b1;
      tick();
      chk("xfer_valid", valid_a, 0);
      chk("overrun_sticky", ovr_a, 1);

      align_a();
      for (int p = 0; p < 9; p++) begin
         spike = (p == 1 || p == 4);
         tick();
      end
      spike = 1'b0;
      chk("pre_reset_isi", isi_a, 3);
      reset = 1'b1;
      tick();
      chk("mid_reset_rate", rate_a, 0);
      chk("mid_reset_isi", isi_a, 0);
      chk("mid_reset_valid", valid_a, 0);
      chk("mid_reset_overrun", ovr_a, 0);
      reset = 1'b0;
      spike = 1'b1;
      tick();
      spike = 1'b0;
      chk("first_onset_no_isi", isi_a, 0);
      for (t = 2; t <= 40; t++) begin
         tick();
         if (valid_a) break;
      end
      chk("post_reset_window", t, 16);
      chk("post_reset_rate", rate_a, 1);

      for (int i = 0; i < 3000; i++) begin
         spike = ($urandom_range(0, 2) == 0);
         en    = ($urandom_range(0, 7) != 0);
         ready = ($urandom_range(0, 3) != 0);
         if (i == 1500) reset = 1'b1;
         tick();
         reset = 1'b0;
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
